// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the IF/ID pipeline record used by the fetch stage.
package riscv_pkg;

    localparam int XLEN             = 32;
    localparam int INSTR_ALIGN_BITS = 2;

    localparam logic [XLEN-1:0] RV_NOP      = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK  = XLEN'((1 << INSTR_ALIGN_BITS) - 1);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Drop the low address bits so redirects always land on a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect/stall/sequential next-PC selection.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4;

    // Natural 32-bit overflow gives the required wrap from the top word to zero.
    assign pc_plus4 = pc_q + INSTR_BYTES;

    always_comb begin
        pc_d = pc_plus4;
        if (pc_src) begin
            pc_d = align_pc(pc_target);
        end else if (stall_if) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sub-module, IF/ID pipeline register and fetch counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_if,
    input  logic            flush_id,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_data,
    output logic [XLEN-1:0] instr_id,
    output logic [XLEN-1:0] pc_id,
    output logic [XLEN-1:0] pc_plus4_id,
    output logic            valid_id,
    output logic [XLEN-1:0] fetch_count
);

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    ifid_t           ifid_q;
    ifid_t           ifid_d;
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] count_d;
    logic            load;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_if  (stall_if),
        .pc_src    (pc_src),
        .pc_target (pc_target),
        .pc_o      (pc),
        .pc_plus4_o(pc_plus4)
    );

    // imem_data only feeds the IF/ID register, never the address path.
    assign imem_addr = pc;

    always_comb begin
        ifid_d = ifid_q;
        load   = 1'b0;
        if (flush_id) begin
            ifid_d = BUBBLE;
        end else if (!stall_if) begin
            ifid_d = '{instr: imem_data, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
            load   = 1'b1;
        end
        count_d = count_q + XLEN'(load);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q  <= BUBBLE;
            count_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign instr_id    = ifid_q.instr;
    assign pc_id       = ifid_q.pc;
    assign pc_plus4_id = ifid_q.pc_plus4;
    assign valid_id    = ifid_q.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table plus randomized run against a reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_if;
    logic        flush_id;
    logic        pc_src;
    logic [31:0] pc_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_if   (stall_if),
        .flush_id   (flush_id),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr_id   (instr_id),
        .pc_id      (pc_id),
        .pc_plus4_id(pc_plus4_id),
        .valid_id   (valid_id),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Synthetic instruction memory: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = mem_word(imem_addr);

    typedef struct {
        bit          rst_n;
        bit          stall;
        bit          flush;
        bit          src;
        logic [31:0] target;
        logic [31:0] e_addr;
        logic [31:0] e_pcid;
        bit          e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pcid, m_p4, m_cnt;
    bit          m_valid;

    function automatic vec_t mk(bit r, bit s, bit f, bit p, logic [31:0] t,
                                logic [31:0] ea, logic [31:0] ep, bit ev, logic [31:0] ec);
        vec_t v;
        v.rst_n = r; v.stall = s; v.flush = f; v.src = p; v.target = t;
        v.e_addr = ea; v.e_pcid = ep; v.e_valid = ev; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit f, input bit p, input logic [31:0] t);
        rst_n = r; stall_if = s; flush_id = f; pc_src = p; pc_target = t;
        // Model advances from the same inputs and the pre-edge PC.
        if (!r) begin
            m_pc = 32'h0; m_instr = NOP; m_pcid = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        end else begin
            if (f) begin
                m_instr = NOP; m_pcid = 0; m_p4 = 0; m_valid = 0;
            end else if (!s) begin
                m_instr = mem_word(m_pc); m_pcid = m_pc; m_p4 = m_pc + 32'd4;
                m_valid = 1; m_cnt = m_cnt + 1;
            end
            if (p)      m_pc = {t[31:2], 2'b00};
            else if (!s) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int n);
        check("rnd_addr",  imem_addr,   m_pc);
        check("rnd_instr", instr_id,    m_instr);
        check("rnd_pcid",  pc_id,       m_pcid);
        check("rnd_p4",    pc_plus4_id, m_p4);
        check("rnd_valid", {31'b0, valid_id}, {31'b0, m_valid});
        check("rnd_cnt",   fetch_count, m_cnt);
        $display("rnd %0d: addr=%h pc_id=%h valid=%0b cnt=%0d", n, imem_addr, pc_id, valid_id, fetch_count);
    endtask

    initial begin
        rst_n = 0; stall_if = 0; flush_id = 0; pc_src = 0; pc_target = 0;
        m_pc = 0; m_instr = NOP; m_pcid = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;

        // Directed table: each row is one clock with the state expected after it.
        vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        32'h0,        0, 0)); // reset
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h4,        32'h0,        1, 1));
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h8,        32'h4,        1, 2));
        vecs.push_back(mk(1,1,0,0,32'h0,        32'h8,        32'h4,        1, 2)); // stall x2
        vecs.push_back(mk(1,1,0,0,32'h0,        32'h8,        32'h4,        1, 2));
        vecs.push_back(mk(1,0,0,0,32'h0,        32'hC,        32'h8,        1, 3));
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h10,       32'hC,        1, 4));
        vecs.push_back(mk(1,0,1,1,32'h42,       32'h40,       32'h0,        0, 4)); // redirect+flush
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h44,       32'h40,       1, 5));
        vecs.push_back(mk(1,1,0,1,32'h80,       32'h80,       32'h40,       1, 5)); // redirect beats stall
        vecs.push_back(mk(1,1,1,0,32'h0,        32'h80,       32'h0,        0, 5)); // flush beats stall
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h84,       32'h80,       1, 6));
        vecs.push_back(mk(1,0,0,1,32'hFFFF_FFFC,32'hFFFF_FFFC,32'h84,       1, 7)); // wrong-path load kept
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,        32'hFFFF_FFFC,1, 8)); // PC wrap
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h4,        32'h0,        1, 9));
        vecs.push_back(mk(1,0,0,1,32'h20,       32'h20,       32'h4,        1, 10));
        vecs.push_back(mk(0,1,0,1,32'h100,      32'h0,        32'h0,        0, 0)); // reset beats all
        vecs.push_back(mk(1,0,0,0,32'h0,        32'h4,        32'h0,        1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [31:0] e_instr, e_p4;
            v = vecs[i];
            step(v.rst_n, v.stall, v.flush, v.src, v.target);
            e_instr = v.e_valid ? mem_word(v.e_pcid) : NOP;
            e_p4    = v.e_valid ? v.e_pcid + 32'd4 : 32'h0;
            check("vec_addr",  imem_addr,   v.e_addr);
            check("vec_instr", instr_id,    e_instr);
            check("vec_pcid",  pc_id,       v.e_pcid);
            check("vec_p4",    pc_plus4_id, e_p4);
            check("vec_valid", {31'b0, valid_id}, {31'b0, v.e_valid});
            check("vec_cnt",   fetch_count, v.e_cnt);
            $display("vec %0d: addr=%h instr=%h pc_id=%h valid=%0b cnt=%0d",
                     i, imem_addr, instr_id, pc_id, valid_id, fetch_count);
        end

        // Hand sequence: reset held several cycles with every control asserted.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 32'h0000_0ABC);
            check_model(1000 + i);
        end
        step(1, 0, 0, 0, 32'h0);
        check_model(1003);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            bit r, s, f, p;
            logic [31:0] t;
            r = ($urandom_range(0, 31) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 7) == 0);
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            step(r, s, f, p, t);
            check_model(n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
